// File: rtl/axo_timer_irq.sv
// Memory-mapped prescaled 32-bit timer with compare match, software-set
// interrupt lines, per-line enables and a registered level irq output.
module axo_timer_irq #(
  parameter logic [31:0] BASE       = 32'h0000_1000,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [1:0]  mem_asize,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic [15:0] irq
);

  localparam int unsigned IRQ_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam logic [2:0] OFF_CTRL  = 3'd0;
  localparam logic [2:0] OFF_COUNT = 3'd1;
  localparam logic [2:0] OFF_CMP   = 3'd2;
  localparam logic [2:0] OFF_PEND  = 3'd3;
  localparam logic [2:0] OFF_ENA   = 3'd4;
  localparam logic [2:0] OFF_SWSET = 3'd5;

  logic                  en_q, en_d;
  logic                  autoreload_q, autoreload_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [DATA_W-1:0]     count_q, count_d;
  logic [DATA_W-1:0]     cmp_q, cmp_d;
  logic [IRQ_W-1:0]      pending_q, pending_d;
  logic [IRQ_W-1:0]      enable_q, enable_d;
  logic [IRQ_W-1:0]      irq_q, irq_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  ready_q, ready_d;

  logic                  hit_c, wr_c, rd_c, tick_c, hw_set_c;
  logic [2:0]            off_c;
  logic [DATA_W-1:0]     rd_val_c;
  logic [IRQ_W-1:0]      w1c_c, swset_c;

  // Decode, read mux, prescaler/counter and pending-state next values.
  always_comb begin
    hit_c        = (mem_addr[31:5] == BASE[31:5]) && (mem_addr[1:0] == 2'b00)
                   && (mem_asize == 2'd2);
    off_c        = mem_addr[4:2];
    wr_c         = hit_c && mem_we;
    rd_c         = hit_c && mem_re && !mem_we;
    rd_val_c     = '0;
    w1c_c        = '0;
    swset_c      = '0;
    hw_set_c     = 1'b0;
    en_d         = en_q;
    autoreload_d = autoreload_q;
    div_d        = div_q;
    cmp_d        = cmp_q;
    enable_d     = enable_q;
    count_d      = count_q;

    case (off_c)
      OFF_CTRL: begin
        rd_val_c[0]               = en_q;
        rd_val_c[1]               = autoreload_q;
        rd_val_c[8 +: PRESCALE_W] = div_q;
      end
      OFF_COUNT: rd_val_c = count_q;
      OFF_CMP:   rd_val_c = cmp_q;
      OFF_PEND:  rd_val_c[IRQ_W-1:0] = pending_q;
      OFF_ENA:   rd_val_c[IRQ_W-1:0] = enable_q;
      default:   rd_val_c = '0;
    endcase

    tick_c = en_q && (pre_q == div_q);
    if (!en_q || tick_c) pre_d = '0;
    else                 pre_d = pre_q + PRESCALE_W'(1);

    // A bus write to COUNT overrides the tick entirely, including the match.
    if (wr_c && (off_c == OFF_COUNT)) begin
      count_d = mem_wdata;
    end else if (tick_c) begin
      if (count_q == cmp_q) begin
        hw_set_c = 1'b1;
        count_d  = autoreload_q ? '0 : count_q + 32'd1;
      end else begin
        count_d  = count_q + 32'd1;
      end
    end

    if (wr_c) begin
      case (off_c)
        OFF_CTRL: begin
          en_d         = mem_wdata[0];
          autoreload_d = mem_wdata[1];
          div_d        = mem_wdata[8 +: PRESCALE_W];
        end
        OFF_CMP:   cmp_d    = mem_wdata;
        OFF_PEND:  w1c_c    = mem_wdata[IRQ_W-1:0];
        OFF_ENA:   enable_d = mem_wdata[IRQ_W-1:0];
        OFF_SWSET: swset_c  = mem_wdata[IRQ_W-1:0];
        default: ;
      endcase
    end

    // Hardware set is OR-ed after the clear so it wins over a same-cycle W1C.
    pending_d    = (pending_q & ~w1c_c) | swset_c;
    pending_d[0] = pending_d[0] | hw_set_c;
    irq_d        = pending_q & enable_q;
    rdata_d      = rd_c ? rd_val_c : rdata_q;
    ready_d      = hit_c && (mem_re || mem_we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q         <= 1'b0;
      autoreload_q <= 1'b0;
      div_q        <= '0;
      pre_q        <= '0;
      count_q      <= '0;
      cmp_q        <= 32'hFFFF_FFFF;
      pending_q    <= '0;
      enable_q     <= '0;
      irq_q        <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
    end else begin
      en_q         <= en_d;
      autoreload_q <= autoreload_d;
      div_q        <= div_d;
      pre_q        <= pre_d;
      count_q      <= count_d;
      cmp_q        <= cmp_d;
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      irq_q        <= irq_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign irq       = irq_q;

endmodule
